// File: rtl/approx_mon_pkg.sv
// Shared widths, FSM encoding and sample record for the approximate multiplier error monitor.
// The optional squared-error path is enabled by defining APPROX_MON_SQERR_EN.
package approx_mon_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int ED_W   = 16;
  localparam int SQ_W   = 48;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] prod;
  } mon_sample_t;

endpackage

// File: rtl/approx_ed_calc.sv
// Combinational exact product and error distance |a*b - prod| for one sample.
module approx_ed_calc
  import approx_mon_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] prod,
  output logic [PROD_W-1:0] exact,
  output logic [ED_W-1:0]   ed
);

  logic [PROD_W:0] diff;
  logic [PROD_W:0] diff_neg;

  assign exact    = PROD_W'(a) * PROD_W'(b);
  // 17-bit signed difference covers -65025..65535 without wrap
  assign diff     = {1'b0, prod} - {1'b0, exact};
  assign diff_neg = -diff;
  assign ed       = diff[PROD_W] ? diff_neg[ED_W-1:0] : diff[ED_W-1:0];

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Windowed error statistics for an 8x8 approximate multiplier, reported via valid/ready.
// Define APPROX_MON_SQERR_EN to also accumulate the saturating sum of ED^2 on rpt_sum_sq.
module approx_mul_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int ACC_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_a,
  input  logic [OP_W-1:0]     in_b,
  input  logic [PROD_W-1:0]   in_prod,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [ACC_W-1:0]    rpt_sum_ed,
  output logic [WIN_LOG2:0]   rpt_err_cnt,
  output logic [ED_W-1:0]     rpt_max_ed,
  output logic [OP_W-1:0]     rpt_max_a,
  output logic [OP_W-1:0]     rpt_max_b,
  output logic [SQ_W-1:0]     rpt_sum_sq
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_N = {1'b1, {WIN_LOG2{1'b0}}};

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCUM  = ST_ACCUM;
  localparam logic [1:0] DRAIN  = ST_DRAIN;
  localparam logic [1:0] REPORT = ST_REPORT;

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              fire;
  logic              clr;
  logic              s1_vld;
  mon_sample_t       s1;

  logic [PROD_W-1:0] unused_exact;
  logic [ED_W-1:0]   ed;

  logic [ACC_W-1:0]  sum_ed;
  logic [ACC_W:0]    sum_add;
  logic [CNT_W-1:0]  err_cnt;
  logic [ED_W-1:0]   max_ed;
  logic [OP_W-1:0]   max_a, max_b;

  assign in_ready  = (state == ACCUM) && (cnt < WIN_N);
  assign fire      = in_valid && in_ready;
  assign clr       = (state == IDLE) && start;
  assign busy      = (state != IDLE);
  assign rpt_valid = (state == REPORT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACCUM;
      ACCUM:   if (fire && (cnt == WIN_N - CNT_W'(1))) state_nx = DRAIN;
      DRAIN:   if (!s1_vld) state_nx = REPORT;
      REPORT:  if (rpt_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // stage 1: register the accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      state  <= state_nx;
      s1_vld <= fire;
      if (fire) s1 <= '{a: in_a, b: in_b, prod: in_prod};
      if (clr)       cnt <= '0;
      else if (fire) cnt <= cnt + CNT_W'(1);
    end
  end

  // stage 2: error distance and statistics update
  approx_ed_calc u_ed (
    .a     (s1.a),
    .b     (s1.b),
    .prod  (s1.prod),
    .exact (unused_exact),
    .ed    (ed)
  );

  assign sum_add = {1'b0, sum_ed} + (ACC_W+1)'(ed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_ed  <= '0;
      err_cnt <= '0;
      max_ed  <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (clr) begin
      sum_ed  <= '0;
      err_cnt <= '0;
      max_ed  <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (s1_vld) begin
      sum_ed <= sum_add[ACC_W] ? '1 : sum_add[ACC_W-1:0];
      if (ed != '0) err_cnt <= err_cnt + CNT_W'(1);
      // strict compare keeps the earliest sample on ties
      if (ed > max_ed) begin
        max_ed <= ed;
        max_a  <= s1.a;
        max_b  <= s1.b;
      end
    end
  end

  assign rpt_sum_ed  = sum_ed;
  assign rpt_err_cnt = err_cnt;
  assign rpt_max_ed  = max_ed;
  assign rpt_max_a   = max_a;
  assign rpt_max_b   = max_b;

`ifdef APPROX_MON_SQERR_EN
  logic [31:0]     ed_sq;
  logic [SQ_W:0]   sq_add;
  logic [SQ_W-1:0] sum_sq;

  assign ed_sq  = 32'(ed) * 32'(ed);
  assign sq_add = {1'b0, sum_sq} + (SQ_W+1)'(ed_sq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sum_sq <= '0;
    else if (clr)    sum_sq <= '0;
    else if (s1_vld) sum_sq <= sq_add[SQ_W] ? '1 : sq_add[SQ_W-1:0];
  end

  assign rpt_sum_sq = sum_sq;
`else
  assign rpt_sum_sq = '0;
`endif

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Directed bench: 4-sample windows on a 32-bit and an 8-bit accumulator instance.
module tb_approx_mul_err_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic [15:0] in_prod = '0;
  logic        rpt_ready = 1'b0;

  logic        busy, in_ready, rpt_valid;
  logic [31:0] rpt_sum_ed;
  logic [2:0]  rpt_err_cnt;
  logic [15:0] rpt_max_ed;
  logic [7:0]  rpt_max_a, rpt_max_b;
  logic [47:0] rpt_sum_sq;

  logic        u8_busy, u8_in_ready, u8_rpt_valid;
  logic [7:0]  u8_sum;
  logic [2:0]  u8_cnt;
  logic [15:0] u8_max;
  logic [7:0]  u8_ma, u8_mb;
  logic [47:0] u8_sq;

  int checks = 0;
  int errors = 0;

`ifdef APPROX_MON_SQERR_EN
  localparam logic [47:0] SQ_EXP = 48'd25;
`else
  localparam logic [47:0] SQ_EXP = 48'd0;
`endif

  always #5 clk = ~clk;

  approx_mul_err_monitor #(.WIN_LOG2(2), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_sum_ed(rpt_sum_ed),
    .rpt_err_cnt(rpt_err_cnt), .rpt_max_ed(rpt_max_ed), .rpt_max_a(rpt_max_a),
    .rpt_max_b(rpt_max_b), .rpt_sum_sq(rpt_sum_sq)
  );

  approx_mul_err_monitor #(.WIN_LOG2(2), .ACC_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .busy(u8_busy),
    .in_valid(in_valid), .in_ready(u8_in_ready), .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
    .rpt_valid(u8_rpt_valid), .rpt_ready(rpt_ready), .rpt_sum_ed(u8_sum),
    .rpt_err_cnt(u8_cnt), .rpt_max_ed(u8_max), .rpt_max_a(u8_ma),
    .rpt_max_b(u8_mb), .rpt_sum_sq(u8_sq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    @(negedge clk);
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_prod = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_rpt();
    for (int i = 0; i < 20 && !rpt_valid; i++) @(negedge clk);
    chk("rpt_valid_timeout", rpt_valid, 1);
  endtask

  task automatic consume();
    @(negedge clk); rpt_ready = 1'b1;
    @(negedge clk); rpt_ready = 1'b0;
    chk("rpt_valid_after_hs", rpt_valid, 0);
    chk("busy_after_hs", busy, 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rpt_valid", rpt_valid, 0);
    chk("rst_sum", rpt_sum_ed, 0);
    chk("rst_max", rpt_max_ed, 0);
    chk("rst_sq", rpt_sum_sq, 0);

    // 1: exact products only
    do_start();
    repeat (4) send(8'd10, 8'd20, 16'd200);
    wait_rpt();
    chk("t1_sum", rpt_sum_ed, 0);
    chk("t1_cnt", rpt_err_cnt, 0);
    chk("t1_max", rpt_max_ed, 0);
    chk("t1_max_a", rpt_max_a, 0);
    chk("t1_max_b", rpt_max_b, 0);
    consume();

    // 2: EDs 1,0,5,3 with exact report latency
    do_start();
    send(8'd1, 8'd1, 16'd2);
    send(8'd3, 8'd4, 16'd12);
    send(8'd255, 8'd255, 16'd65020);
    send(8'd7, 8'd7, 16'd46);
    @(negedge clk); chk("t2_lat_t1", rpt_valid, 0);
    @(negedge clk); chk("t2_lat_t2", rpt_valid, 0);
    chk("t2_sum_at_t2", rpt_sum_ed, 9);
    @(negedge clk); chk("t2_lat_t3", rpt_valid, 1);
    chk("t2_sum", rpt_sum_ed, 9);
    chk("t2_cnt", rpt_err_cnt, 3);
    chk("t2_max", rpt_max_ed, 5);
    chk("t2_max_a", rpt_max_a, 255);
    chk("t2_max_b", rpt_max_b, 255);
    chk("t2_u8_sum", u8_sum, 9);
    consume();

    // 3a: overestimate gives positive ED
    do_start();
    send(8'd2, 8'd3, 16'd10);
    send(8'd5, 8'd5, 16'd25);
    send(8'd6, 8'd6, 16'd36);
    send(8'd1, 8'd1, 16'd1);
    wait_rpt();
    chk("t3_sum", rpt_sum_ed, 4);
    chk("t3_cnt", rpt_err_cnt, 1);
    chk("t3_max", rpt_max_ed, 4);
    consume();

    // 3b: tie on ED 4 keeps the first sample
    do_start();
    send(8'd2, 8'd3, 16'd10);
    send(8'd6, 8'd6, 16'd40);
    send(8'd0, 8'd0, 16'd0);
    send(8'd9, 8'd9, 16'd81);
    wait_rpt();
    chk("t3b_max", rpt_max_ed, 4);
    chk("t3b_max_a", rpt_max_a, 2);
    chk("t3b_max_b", rpt_max_b, 3);

    // 4: back-pressure, stray start and stray samples are ignored
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_prod = 16'd0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clk);
      chk("t4_rpt_valid", rpt_valid, 1);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_busy", busy, 1);
      chk("t4_sum", rpt_sum_ed, 8);
      chk("t4_cnt", rpt_err_cnt, 2);
    end
    start = 1'b0; in_valid = 1'b0;
    consume();
    chk("t4_sum_readable", rpt_sum_ed, 8);
    chk("t4_idle_in_ready", in_ready, 0);

    // 5: asynchronous reset mid-window
    do_start();
    send(8'd1, 8'd1, 16'd2);
    send(8'd1, 8'd1, 16'd2);
    @(negedge clk);
    chk("t5_partial_sum", rpt_sum_ed, 1);
    rst = 1'b1; #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_rpt_valid", rpt_valid, 0);
    chk("t5_rst_sum", rpt_sum_ed, 0);
    chk("t5_rst_cnt", rpt_err_cnt, 0);
    chk("t5_rst_max_a", rpt_max_a, 0);
    chk("t5_rst_u8_busy", u8_busy, 0);
    chk("t5_rst_u8_in_ready", u8_in_ready, 0);
    @(negedge clk); rst = 1'b0;
    do_start();
    send(8'd3, 8'd3, 16'd11);
    send(8'd4, 8'd4, 16'd14);
    send(8'd0, 8'd0, 16'd2);
    send(8'd10, 8'd10, 16'd102);
    wait_rpt();
    chk("t5_sum", rpt_sum_ed, 8);
    chk("t5_cnt", rpt_err_cnt, 4);
    chk("t5_max_a", rpt_max_a, 3);
    consume();

    // 6a: 8-bit accumulator saturates
    do_start();
    send(8'd10, 8'd10, 16'd200);
    send(8'd20, 8'd5, 16'd0);
    send(8'd0, 8'd0, 16'd100);
    send(8'd10, 8'd20, 16'd100);
    wait_rpt();
    chk("t6_u8_rpt_valid", u8_rpt_valid, 1);
    chk("t6_u8_sum_sat", u8_sum, 255);
    chk("t6_u8_cnt", u8_cnt, 4);
    chk("t6_u8_max", u8_max, 100);
    chk("t6_u8_max_a", u8_ma, 10);
    chk("t6_u8_max_b", u8_mb, 10);
    chk("t6_sum_wide", rpt_sum_ed, 400);
    consume();

    // 6b: squared-error sum for EDs 3,4,0,0
    do_start();
    send(8'd1, 8'd1, 16'd4);
    send(8'd2, 8'd2, 16'd0);
    send(8'd1, 8'd1, 16'd1);
    send(8'd2, 8'd2, 16'd4);
    wait_rpt();
    chk("t6_sum", rpt_sum_ed, 7);
    chk("t6_sum_sq", rpt_sum_sq, SQ_EXP);
    chk("t6_u8_sum_sq", u8_sq, SQ_EXP);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
